// File: rtl/arp_ctrl.sv
// ARP sequencing controller: single-entry PC cache, reply scheduling and request timeout/retry.
// Optional macro ARP_GRATUITOUS_EN sends one announce request for FPGA_IP right after reset.
module arp_ctrl #(
   parameter logic [47:0] FPGA_MAC    = 48'h00_11_22_33_44_55,
   parameter logic [31:0] FPGA_IP     = 32'hc0_a8_00_03,
   parameter logic [31:0] TARGET_IP   = 32'hc0_a8_00_02,
   parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000,
   parameter logic [31:0] MAX_RETRY   = 32'd3,
   parameter logic [31:0] AGE_CYC     = 32'd1_250_000_000
) (
   input  logic        arp_rx_clk,
   input  logic        rstn,
   input  logic        arp_rx_done,
   input  logic        arp_rx_op,
   input  logic [47:0] rx_src_mac,
   input  logic [31:0] rx_src_ip,
   input  logic        udp_tx_req,
   input  logic        arp_tx_busy,
   input  logic        arp_tx_done,
   output logic        arp_tx_start,
   output logic        arp_tx_type,
   output logic [47:0] tx_dst_mac,
   output logic [31:0] tx_dst_ip,
   output logic [47:0] tx_src_mac,
   output logic [31:0] tx_src_ip,
   output logic        pc_mac_valid,
   output logic [47:0] pc_mac,
   output logic        arp_fail,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REP_WAIT  = 3'd1,
      S_REP_TX    = 3'd2,
      S_REQ_WAIT  = 3'd3,
      S_REQ_TX    = 3'd4,
      S_REQ_PEND  = 3'd5,
      S_GRAT_WAIT = 3'd6,
      S_GRAT_TX   = 3'd7
   } state_t;

`ifdef ARP_GRATUITOUS_EN
   localparam state_t S_RESET = S_GRAT_WAIT;
`else
   localparam state_t S_RESET = S_IDLE;
`endif

   localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

   state_t      r_state;
   state_t      r_ret_state;
   logic        r_rep_pend;
   logic [47:0] r_rep_mac;
   logic [31:0] r_rep_ip;
   logic [31:0] r_timer;
   logic [31:0] r_retry;
   logic [31:0] r_age;
   logic        r_tx_start;
   logic        r_tx_type;
   logic [47:0] r_tx_dst_mac;
   logic [31:0] r_tx_dst_ip;
   logic [47:0] r_tx_src_mac;
   logic [31:0] r_tx_src_ip;
   logic        r_pc_valid;
   logic [47:0] r_pc_mac;
   logic        r_fail;

   wire w_rx_req   = arp_rx_done && arp_rx_op;
   wire w_rx_cache = arp_rx_done && (rx_src_ip == TARGET_IP);

   always_ff @(posedge arp_rx_clk) begin
      if (!rstn) begin
         r_state      <= S_RESET;
         r_ret_state  <= S_IDLE;
         r_rep_pend   <= 1'b0;
         r_rep_mac    <= '0;
         r_rep_ip     <= '0;
         r_timer      <= '0;
         r_retry      <= '0;
         r_age        <= '0;
         r_tx_start   <= 1'b0;
         r_tx_type    <= 1'b0;
         r_tx_dst_mac <= '0;
         r_tx_dst_ip  <= '0;
         r_tx_src_mac <= '0;
         r_tx_src_ip  <= '0;
         r_pc_valid   <= 1'b0;
         r_pc_mac     <= '0;
         r_fail       <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;

         // Age counter stops at its terminal value, so it never wraps.
         if (r_pc_valid) begin
            if (r_age == AGE_CYC - 32'd1) r_pc_valid <= 1'b0;
            else                          r_age      <= r_age + 32'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (r_rep_pend) begin
                  r_state     <= S_REP_WAIT;
                  r_ret_state <= S_IDLE;
               end else if (udp_tx_req && !r_pc_valid && !r_fail) begin
                  r_state <= S_REQ_WAIT;
               end
            end
            S_REP_WAIT: begin
               if (!arp_tx_busy) begin
                  r_tx_start   <= 1'b1;
                  r_tx_type    <= 1'b0;
                  r_tx_dst_mac <= r_rep_mac;
                  r_tx_dst_ip  <= r_rep_ip;
                  r_tx_src_mac <= FPGA_MAC;
                  r_tx_src_ip  <= FPGA_IP;
                  r_rep_pend   <= 1'b0;
                  r_state      <= S_REP_TX;
               end
            end
            S_REP_TX: begin
               if (arp_tx_done) r_state <= r_ret_state;
            end
            S_REQ_WAIT: begin
               if (r_rep_pend) begin
                  r_state     <= S_REP_WAIT;
                  r_ret_state <= S_IDLE;
               end else if (!arp_tx_busy) begin
                  r_tx_start   <= 1'b1;
                  r_tx_type    <= 1'b1;
                  r_tx_dst_mac <= BCAST_MAC;
                  r_tx_dst_ip  <= TARGET_IP;
                  r_tx_src_mac <= FPGA_MAC;
                  r_tx_src_ip  <= FPGA_IP;
                  if (r_retry != '1) r_retry <= r_retry + 32'd1;
                  r_state      <= S_REQ_TX;
               end
            end
            S_REQ_TX: begin
               if (arp_tx_done) begin
                  r_state <= S_REQ_PEND;
                  r_timer <= '0;
               end
            end
            S_REQ_PEND: begin
               // A reply detour leaves r_timer untouched so the wait resumes afterwards.
               if (r_pc_valid) begin
                  r_state <= S_IDLE;
               end else if (r_rep_pend) begin
                  r_state     <= S_REP_WAIT;
                  r_ret_state <= S_REQ_PEND;
               end else if (r_timer == TIMEOUT_CYC - 32'd1) begin
                  if (r_retry < MAX_RETRY) begin
                     r_state <= S_REQ_WAIT;
                  end else begin
                     r_fail  <= 1'b1;
                     r_retry <= '0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_timer <= r_timer + 32'd1;
               end
            end
`ifdef ARP_GRATUITOUS_EN
            S_GRAT_WAIT: begin
               if (!arp_tx_busy) begin
                  r_tx_start   <= 1'b1;
                  r_tx_type    <= 1'b1;
                  r_tx_dst_mac <= BCAST_MAC;
                  r_tx_dst_ip  <= FPGA_IP;
                  r_tx_src_mac <= FPGA_MAC;
                  r_tx_src_ip  <= FPGA_IP;
                  r_state      <= S_GRAT_TX;
               end
            end
            S_GRAT_TX: begin
               if (arp_tx_done) r_state <= S_IDLE;
            end
`endif
            default: r_state <= S_IDLE;
         endcase

         // Receiver results are applied last so a new request or refresh wins same-cycle races.
         if (w_rx_req) begin
            r_rep_pend <= 1'b1;
            r_rep_mac  <= rx_src_mac;
            r_rep_ip   <= rx_src_ip;
         end
         if (w_rx_cache) begin
            r_pc_mac   <= rx_src_mac;
            r_pc_valid <= 1'b1;
            r_age      <= '0;
            r_fail     <= 1'b0;
            r_retry    <= '0;
         end
      end
   end

   assign arp_tx_start = r_tx_start;
   assign arp_tx_type  = r_tx_type;
   assign tx_dst_mac   = r_tx_dst_mac;
   assign tx_dst_ip    = r_tx_dst_ip;
   assign tx_src_mac   = r_tx_src_mac;
   assign tx_src_ip    = r_tx_src_ip;
   assign pc_mac_valid = r_pc_valid;
   assign pc_mac       = r_pc_mac;
   assign arp_fail     = r_fail;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl: vector table for single receive events plus
// hand-written sequences for retry, timer freeze, aging and reset mid-frame.
module tb_arp_ctrl;

   localparam int          TIMEOUT = 100;
   localparam int          MAXR    = 3;
   localparam int          AGE     = 1000;
   localparam int          FRAME   = 10;
   localparam logic [31:0] TIP     = 32'hC0A8_0002;
   localparam logic [31:0] OIP     = 32'hC0A8_0009;
   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        arp_rx_done = 1'b0;
   logic        arp_rx_op = 1'b0;
   logic [47:0] rx_src_mac = '0;
   logic [31:0] rx_src_ip = '0;
   logic        udp_tx_req = 1'b0;
   logic        arp_tx_busy;
   logic        arp_tx_done;
   logic        arp_tx_start;
   logic        arp_tx_type;
   logic [47:0] tx_dst_mac;
   logic [31:0] tx_dst_ip;
   logic [47:0] tx_src_mac;
   logic [31:0] tx_src_ip;
   logic        pc_mac_valid;
   logic [47:0] pc_mac;
   logic        arp_fail;
   logic [2:0]  dbg_state;

   logic mdl_busy = 1'b0, mdl_done = 1'b0;
   logic man_busy = 1'b0, man_done = 1'b0;
   logic tx_model_en = 1'b1;
   int   mdl_cnt = 0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   assign arp_tx_busy = tx_model_en ? mdl_busy : man_busy;
   assign arp_tx_done = tx_model_en ? mdl_done : man_done;

   arp_ctrl #(
      .TIMEOUT_CYC(TIMEOUT), .MAX_RETRY(MAXR), .AGE_CYC(AGE)
   ) dut (
      .arp_rx_clk(clk), .rstn(rstn), .arp_rx_done(arp_rx_done), .arp_rx_op(arp_rx_op),
      .rx_src_mac(rx_src_mac), .rx_src_ip(rx_src_ip), .udp_tx_req(udp_tx_req),
      .arp_tx_busy(arp_tx_busy), .arp_tx_done(arp_tx_done), .arp_tx_start(arp_tx_start),
      .arp_tx_type(arp_tx_type), .tx_dst_mac(tx_dst_mac), .tx_dst_ip(tx_dst_ip),
      .tx_src_mac(tx_src_mac), .tx_src_ip(tx_src_ip), .pc_mac_valid(pc_mac_valid),
      .pc_mac(pc_mac), .arp_fail(arp_fail), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // start monitor: every observed start pulse with its cycle and frame fields
   int          st_cyc_q[$];
   logic        st_type_q[$];
   logic [47:0] st_mac_q[$];
   logic [31:0] st_ip_q[$];
   initial forever begin
      @(posedge clk); #1;
      if (arp_tx_start) begin
         st_cyc_q.push_back(cyc);
         st_type_q.push_back(arp_tx_type);
         st_mac_q.push_back(tx_dst_mac);
         st_ip_q.push_back(tx_dst_ip);
      end
   end

   // transmitter model: busy for FRAME cycles after a start, then a done pulse
   initial forever begin
      @(posedge clk); #1;
      mdl_done = 1'b0;
      if (!rstn) begin
         mdl_cnt  = 0;
         mdl_busy = 1'b0;
      end else if (mdl_cnt > 0) begin
         mdl_cnt = mdl_cnt - 1;
         if (mdl_cnt == 0) begin
            mdl_busy = 1'b0;
            mdl_done = 1'b1;
         end
      end else if (arp_tx_start) begin
         mdl_busy = 1'b1;
         mdl_cnt  = FRAME;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      udp_tx_req = 1'b0;
      arp_rx_done = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic rx_pulse(input logic op, input logic [47:0] mac, input logic [31:0] ip,
                           output int drive_cyc);
      drive_cyc   = cyc;
      arp_rx_op   = op;
      rx_src_mac  = mac;
      rx_src_ip   = ip;
      arp_rx_done = 1'b1;
      tick();
      arp_rx_done = 1'b0;
   endtask

   task automatic wait_starts(input int n, input int budget);
      for (int i = 0; i < budget && st_cyc_q.size() < n; i++) tick();
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick();
   endtask

   // scoreboard compare
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        op;
      logic [47:0] mac;
      logic [31:0] ip;
      int          exp_starts;
      logic [47:0] exp_dmac;
      logic [31:0] exp_dip;
      logic        exp_valid;
      logic [47:0] exp_pcmac;
   } vec_t;

   vec_t        vecs[4];
   logic [31:0] exp_q[$];
   int          base, d, s, r, fail_cyc;

   initial begin
      vecs[0] = '{1'b1, 48'h0A0B0C0D0E0F, TIP, 1, 48'h0A0B0C0D0E0F, TIP, 1'b1, 48'h0A0B0C0D0E0F};
      vecs[1] = '{1'b1, 48'h112233445566, OIP, 1, 48'h112233445566, OIP, 1'b0, 48'h0};
      vecs[2] = '{1'b0, 48'hDEADBEEF0001, TIP, 0, 48'h0, 32'h0, 1'b1, 48'hDEADBEEF0001};
      vecs[3] = '{1'b0, 48'hCAFEF00D0002, OIP, 0, 48'h0, 32'h0, 1'b0, 48'h0};

      // reset state
      repeat (3) tick();
      chk("rst_start", arp_tx_start, 0);
      chk("rst_type", arp_tx_type, 0);
      chk("rst_dmac", tx_dst_mac, 0);
      chk("rst_dip", tx_dst_ip, 0);
      chk("rst_valid", pc_mac_valid, 0);
      chk("rst_pcmac", pc_mac, 0);
      chk("rst_fail", arp_fail, 0);
      chk("rst_state", dbg_state, 0);

      // table: single receive events
      for (int v = 0; v < 4; v++) begin
         do_reset();
         base = st_cyc_q.size();
         rx_pulse(vecs[v].op, vecs[v].mac, vecs[v].ip, d);
         repeat (FRAME + 8) tick();
         chk($sformatf("v%0d_nstart", v), st_cyc_q.size() - base, vecs[v].exp_starts);
         if (st_cyc_q.size() > base) begin
            chk($sformatf("v%0d_lat", v), st_cyc_q[base] - d, 3);
            chk($sformatf("v%0d_type", v), st_type_q[base], 0);
            chk($sformatf("v%0d_dmac", v), st_mac_q[base], vecs[v].exp_dmac);
            chk($sformatf("v%0d_dip", v), st_ip_q[base], vecs[v].exp_dip);
         end
         chk($sformatf("v%0d_valid", v), pc_mac_valid, vecs[v].exp_valid);
         chk($sformatf("v%0d_pcmac", v), pc_mac, vecs[v].exp_pcmac);
         chk($sformatf("v%0d_state", v), dbg_state, 0);
      end

      // retry until failure: three requests, then arp_fail and silence
      do_reset();
      base = st_cyc_q.size();
      d = cyc;
      udp_tx_req = 1'b1;
      fail_cyc = -1;
      for (int i = 0; i < 1000 && fail_cyc < 0; i++) begin
         tick();
         if (arp_fail) fail_cyc = cyc;
      end
      chk("retry_fail_set", arp_fail, 1);
      chk("retry_nstart", st_cyc_q.size() - base, 3);
      chk("retry_first_lat", st_cyc_q[base] - d, 2);
      s = st_cyc_q[base];
      exp_q.push_back(s + (TIMEOUT + FRAME + 2));
      exp_q.push_back(s + 2 * (TIMEOUT + FRAME + 2));
      for (int k = 1; k <= 2; k++) begin
         chk($sformatf("retry_gap%0d", k), st_cyc_q[base + k], exp_q.pop_front());
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("retry_type%0d", k), st_type_q[base + k], 1);
         chk($sformatf("retry_dip%0d", k), st_ip_q[base + k], TIP);
         chk($sformatf("retry_dmac%0d", k), st_mac_q[base + k], BCAST);
      end
      chk("retry_fail_cyc", fail_cyc, st_cyc_q[base + 2] + FRAME + TIMEOUT + 1);
      repeat (300) tick();
      chk("retry_no4th", st_cyc_q.size() - base, 3);
      chk("retry_fail_sticky", arp_fail, 1);

      // reply arrives while waiting (timer=50): cache fills, no retry
      do_reset();
      base = st_cyc_q.size();
      udp_tx_req = 1'b1;
      wait_starts(base + 1, 50);
      s = st_cyc_q[base];
      wait_until(s + 61);
      rx_pulse(1'b0, 48'h00AABBCCDDEE, TIP, d);
      repeat (2) tick();
      chk("ans_valid", pc_mac_valid, 1);
      chk("ans_pcmac", pc_mac, 48'h00AABBCCDDEE);
      chk("ans_state", dbg_state, 0);
      repeat (300) tick();
      chk("ans_nstart", st_cyc_q.size() - base, 1);
      chk("ans_fail", arp_fail, 0);
      udp_tx_req = 1'b0;

      // incoming request in REQ_PEND: reply served, timer resumes at 40
      do_reset();
      base = st_cyc_q.size();
      udp_tx_req = 1'b1;
      wait_starts(base + 1, 50);
      s = st_cyc_q[base];
      wait_until(s + 50);
      rx_pulse(1'b1, 48'h665544332211, OIP, d);
      wait_starts(base + 3, 400);
      chk("frz_nstart", st_cyc_q.size() - base, 3);
      r = st_cyc_q[base + 1];
      chk("frz_rep_lat", r - d, 3);
      chk("frz_rep_type", st_type_q[base + 1], 0);
      chk("frz_rep_dip", st_ip_q[base + 1], OIP);
      chk("frz_rep_dmac", st_mac_q[base + 1], 48'h665544332211);
      chk("frz_req2_cyc", st_cyc_q[base + 2], r + FRAME + 1 + (TIMEOUT - 40) + 1);
      chk("frz_req2_type", st_type_q[base + 2], 1);
      chk("frz_valid", pc_mac_valid, 0);
      udp_tx_req = 1'b0;

      // aging: valid for exactly AGE cycles, mac retained, then a new request
      do_reset();
      base = st_cyc_q.size();
      rx_pulse(1'b0, 48'h0102030405AB, TIP, d);
      wait_until(d + AGE);
      chk("age_valid_last", pc_mac_valid, 1);
      tick();
      chk("age_expired", pc_mac_valid, 0);
      chk("age_mac_kept", pc_mac, 48'h0102030405AB);
      udp_tx_req = 1'b1;
      wait_starts(base + 1, 10);
      chk("age_nstart", st_cyc_q.size() - base, 1);
      chk("age_req_dip", st_ip_q[base], TIP);
      chk("age_req_type", st_type_q[base], 1);
      udp_tx_req = 1'b0;

      // reset while a request frame is on the wire; late done must be ignored
      tx_model_en = 1'b0;
      man_busy = 1'b0;
      do_reset();
      base = st_cyc_q.size();
      udp_tx_req = 1'b1;
      wait_starts(base + 1, 20);
      man_busy = 1'b1;
      tick();
      chk("mid_state", dbg_state, 4);
      chk("mid_type", arp_tx_type, 1);
      rstn = 1'b0;
      udp_tx_req = 1'b0;
      tick();
      chk("mid_rst_start", arp_tx_start, 0);
      chk("mid_rst_type", arp_tx_type, 0);
      chk("mid_rst_dmac", tx_dst_mac, 0);
      chk("mid_rst_dip", tx_dst_ip, 0);
      chk("mid_rst_state", dbg_state, 0);
      rstn = 1'b1;
      man_busy = 1'b0;
      tick();
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      repeat (5) tick();
      chk("late_done_state", dbg_state, 0);
      chk("late_done_nstart", st_cyc_q.size() - base, 1);
      tx_model_en = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
